if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
//  Instruction-fetch stage plus IF/ID pipeline register; sits directly upstream of id_ex.
//  Owns the PC and runs a one-outstanding-request handshake with instruction memory.
//  Presents a fetched word, its PC+2 and its opcode to decode.
//  Squashes wrong-path fetches on a redirect (pc_mux_not_zero) from EX.
// PARAMETERS
//  RESET_PC   16'h0000  PC value loaded on reset
//  NOP_WORD   16'h0000  IR value for a bubble (BR with nzp=000)
// PORTS
//  clk               in   1   clock; all state updates on posedge
//  reset_n           in   1   asynchronous, active-low reset
//  load              in   1   pipeline advance (0 = downstream stall; IF/ID holds)
//  pc_mux_not_zero   in   1   redirect request from EX (branch/jump/trap taken)
//  redirect_target   in   16  new PC when pc_mux_not_zero=1
//  imem_resp         in   1   memory completes current read this cycle
//  imem_rdata        in   16  read data, valid when imem_resp=1
//  imem_read         out  1   read request; held high until imem_resp
//  imem_address      out  16  read address; stable while imem_read=1
//  if_id_pc_out      out  16  PC+2 of instruction in IF/ID
//  if_id_ir_out      out  16  instruction word in IF/ID
//  if_id_opcode_out  out  4   if_id_ir_out[15:12]
//  if_id_valid_out   out  1   1 = IF/ID holds a real instruction
// BEHAVIOUR
//  Reset (async, reset_n=0): pc=RESET_PC, state=FETCH, buf empty, if_id_pc_out=0,
//   if_id_ir_out=NOP_WORD, if_id_valid_out=0, imem_read=0 while in reset.
//  PC arithmetic: 16-bit, pc+2 wraps 16'hFFFE -> 16'h0000; bit0 of pc always 0
//   (redirect_target[0] ignored, forced 0).
//  Memory: imem_address = pc in FETCH/SQUASH; request never withdrawn before imem_resp.
//  States:
//   FETCH : imem_read=1.
//    resp & redirect          -> discard word, pc<=target, stay FETCH
//    resp & load & !redirect  -> IF/ID<=word (valid=1, pc_out=pc+2), pc<=pc+2, FETCH
//    resp & !load & !redirect -> buf<=word, HOLD
//    !resp & redirect         -> tgt<=target, SQUASH
//    !resp                    -> stay FETCH
//   SQUASH: imem_read=1, addr = old pc. On resp: discard, pc<=tgt, FETCH.
//    A further redirect in SQUASH overwrites tgt (latest wins).
//   HOLD  : imem_read=0.
//    redirect -> buf dropped, pc<=target, FETCH
//    load     -> IF/ID<=buf, pc<=pc+2, FETCH
//    else       stay HOLD
//  IF/ID register:
//   - Updated only when load=1, except flush.
//   - load=1 with no word available (FETCH w/o resp, SQUASH) -> bubble:
//     valid=0, ir=NOP_WORD, pc_out unchanged.
//   - Flush: pc_mux_not_zero=1 clears valid and ir=NOP_WORD that edge, regardless of load.
//   - Redirect beats every other event in the same cycle.
//  Latency: resp at edge N with load=1 -> instruction visible in IF/ID after edge N;
//   next request issued cycle N+1. Back-to-back 1-cycle memory gives 1 instr/cycle.
//  Reset mid-request: request dropped immediately; memory must tolerate the abort.
// TESTING
//  1 Reset: reset_n=0 mid-fetch -> imem_read=0, valid=0, ir=0000;
//    release -> imem_address=0000, imem_read=1.
//  2 Streaming: 1-cycle resp, words 1234,5678 at 0000,0002 -> IF/ID pc_out 0002,0004;
//    opcode 1,5; valid every cycle.
//  3 Stall: resp with load=0 -> HOLD, imem_read=0, IF/ID unchanged;
//    load=1 -> buffered word appears, fetch resumes at pc+2.
//  4 Redirect mid-request: redirect target 0x3000 while waiting on 3-cycle resp ->
//    old word discarded, next address 3000, IF/ID flushed to valid=0.
//  5 Redirect same cycle as resp and in HOLD -> word dropped, next address = target,
//    no wrong-path instr ever valid.
//  6 Wrap: pc=FFFE, resp -> pc_out 0000, next address 0000.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with IF/ID register: owns the PC, keeps one read outstanding
// to instruction memory, and squashes wrong-path words when EX redirects.
module if_fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_WORD = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic        pc_mux_not_zero,
  input  logic [15:0] redirect_target,
  input  logic        imem_resp,
  input  logic [15:0] imem_rdata,
  output logic        imem_read,
  output logic [15:0] imem_address,
  output logic [15:0] if_id_pc_out,
  output logic [15:0] if_id_ir_out,
  output logic [3:0]  if_id_opcode_out,
  output logic        if_id_valid_out
);

  typedef enum logic [1:0] {FETCH, SQUASH, HOLD} state_t;

  state_t      state;
  logic [15:0] pc, tgt, hold_word;
  logic [15:0] pc_inc, tgt_even;

  assign pc_inc   = pc + 16'd2;
  assign tgt_even = {redirect_target[15:1], 1'b0};

  // Reset gates the request so an in-flight read is dropped the instant reset asserts.
  assign imem_read        = reset_n & (state != HOLD);
  assign imem_address     = pc;
  assign if_id_opcode_out = if_id_ir_out[15:12];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= FETCH;
      pc              <= RESET_PC;
      tgt             <= RESET_PC;
      hold_word       <= NOP_WORD;
      if_id_pc_out    <= 16'h0000;
      if_id_ir_out    <= NOP_WORD;
      if_id_valid_out <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (pc_mux_not_zero) begin
            if (imem_resp) pc <= tgt_even;
            else begin
              tgt   <= tgt_even;
              state <= SQUASH;
            end
          end else if (imem_resp) begin
            if (load) pc <= pc_inc;
            else begin
              hold_word <= imem_rdata;
              state     <= HOLD;
            end
          end
        end
        SQUASH: begin
          // The stale read must complete before the target can be requested.
          if (imem_resp) begin
            pc    <= pc_mux_not_zero ? tgt_even : tgt;
            state <= FETCH;
          end else if (pc_mux_not_zero) tgt <= tgt_even;
        end
        HOLD: begin
          if (pc_mux_not_zero) begin
            pc    <= tgt_even;
            state <= FETCH;
          end else if (load) begin
            pc    <= pc_inc;
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase

      if (pc_mux_not_zero) begin
        if_id_valid_out <= 1'b0;
        if_id_ir_out    <= NOP_WORD;
      end else if (load) begin
        if (state == FETCH && imem_resp) begin
          if_id_valid_out <= 1'b1;
          if_id_ir_out    <= imem_rdata;
          if_id_pc_out    <= pc_inc;
        end else if (state == HOLD) begin
          if_id_valid_out <= 1'b1;
          if_id_ir_out    <= hold_word;
          if_id_pc_out    <= pc_inc;
        end else begin
          if_id_valid_out <= 1'b0;
          if_id_ir_out    <= NOP_WORD;
        end
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: expected IF/ID contents are queued as each word is handed
// to the DUT and popped when the DUT should present it.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        load = 1'b0;
  logic        pc_mux_not_zero = 1'b0;
  logic [15:0] redirect_target = 16'h0000;
  logic        imem_resp = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic        imem_read;
  logic [15:0] imem_address;
  logic [15:0] if_id_pc_out;
  logic [15:0] if_id_ir_out;
  logic [3:0]  if_id_opcode_out;
  logic        if_id_valid_out;

  typedef struct {logic [15:0] pc; logic [15:0] ir;} exp_t;
  exp_t sb[$];

  int vectors = 0;
  int miscompares = 0;

  if_fetch_stage dut (
    .clk(clk), .reset_n(reset_n), .load(load), .pc_mux_not_zero(pc_mux_not_zero),
    .redirect_target(redirect_target), .imem_resp(imem_resp), .imem_rdata(imem_rdata),
    .imem_read(imem_read), .imem_address(imem_address), .if_id_pc_out(if_id_pc_out),
    .if_id_ir_out(if_id_ir_out), .if_id_opcode_out(if_id_opcode_out),
    .if_id_valid_out(if_id_valid_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  function automatic logic [15:0] memw(input logic [15:0] a);
    case (a)
      16'h0000: memw = 16'h1234;
      16'h0002: memw = 16'h5678;
      default:  memw = {a[7:0], a[15:8]} ^ 16'hC3A5;
    endcase
  endfunction

  task automatic push(input logic [15:0] pc, input logic [15:0] ir);
    exp_t e;
    e.pc = pc; e.ir = ir;
    sb.push_back(e);
  endtask

  // Drive one cycle of inputs, then return at the following negedge.
  task automatic step(input logic rs, input logic [15:0] rd, input logic ld,
                      input logic rdr, input logic [15:0] tg);
    imem_resp = rs; imem_rdata = rd; load = ld; pc_mux_not_zero = rdr; redirect_target = tg;
    @(posedge clk);
    @(negedge clk);
    imem_resp = 1'b0; load = 1'b0; pc_mux_not_zero = 1'b0;
  endtask

  task automatic test_reset;
    exp_t e;
    repeat (2) @(negedge clk);
    vectors++;
    if ({imem_read, if_id_valid_out, if_id_ir_out, if_id_pc_out} !== {1'b0, 1'b0, 16'h0, 16'h0}) begin
      miscompares++;
      $display("FAIL reset_state: got %h want %h",
               {imem_read, if_id_valid_out, if_id_ir_out, if_id_pc_out}, 34'h0);
    end
    reset_n = 1'b1;
    #1;
    vectors++;
    if ({imem_read, imem_address} !== {1'b1, 16'h0000}) begin
      miscompares++;
      $display("FAIL reset_release: got %h want %h", {imem_read, imem_address}, 17'h10000);
    end
    push(16'h0002, memw(16'h0000));
    step(1'b1, memw(16'h0000), 1'b1, 1'b0, 16'h0);
    e = sb.pop_front();
    vectors++;
    if ({if_id_valid_out, if_id_pc_out, if_id_ir_out} !== {1'b1, e.pc, e.ir}) begin
      miscompares++;
      $display("FAIL reset_first_fetch: got %h want %h",
               {if_id_valid_out, if_id_pc_out, if_id_ir_out}, {1'b1, e.pc, e.ir});
    end
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if ({imem_read, if_id_valid_out, if_id_ir_out, if_id_pc_out} !== {1'b0, 1'b0, 16'h0, 16'h0}) begin
      miscompares++;
      $display("FAIL reset_mid_fetch: got %h want %h",
               {imem_read, if_id_valid_out, if_id_ir_out, if_id_pc_out}, 34'h0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    vectors++;
    if ({imem_read, imem_address} !== {1'b1, 16'h0000}) begin
      miscompares++;
      $display("FAIL reset_rerelease: got %h want %h", {imem_read, imem_address}, 17'h10000);
    end
  endtask

  task automatic test_stream;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      logic [15:0] a;
      a = 16'(i * 2);
      vectors++;
      if ({imem_read, imem_address} !== {1'b1, a}) begin
        miscompares++;
        $display("FAIL stream_addr: got %h want %h", {imem_read, imem_address}, {1'b1, a});
      end
      push(a + 16'd2, memw(a));
      step(1'b1, memw(a), 1'b1, 1'b0, 16'h0);
      e = sb.pop_front();
      vectors++;
      if ({if_id_valid_out, if_id_pc_out, if_id_ir_out, if_id_opcode_out} !==
          {1'b1, e.pc, e.ir, e.ir[15:12]}) begin
        miscompares++;
        $display("FAIL stream_ifid: got %h want %h",
                 {if_id_valid_out, if_id_pc_out, if_id_ir_out, if_id_opcode_out},
                 {1'b1, e.pc, e.ir, e.ir[15:12]});
      end
    end
    step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
    vectors++;
    if ({if_id_valid_out, if_id_ir_out, if_id_pc_out} !== {1'b0, 16'h0000, 16'h0008}) begin
      miscompares++;
      $display("FAIL stream_bubble: got %h want %h",
               {if_id_valid_out, if_id_ir_out, if_id_pc_out}, {1'b0, 16'h0000, 16'h0008});
    end
  endtask

  task automatic test_stall;
    exp_t e;
    logic [15:0] w;
    w = memw(16'h0008);
    step(1'b1, w, 1'b0, 1'b0, 16'h0);
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    vectors++;
    if ({imem_read, if_id_valid_out, if_id_pc_out} !== {1'b0, 1'b0, 16'h0008}) begin
      miscompares++;
      $display("FAIL stall_hold: got %h want %h",
               {imem_read, if_id_valid_out, if_id_pc_out}, {1'b0, 1'b0, 16'h0008});
    end
    push(16'h000A, w);
    step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
    e = sb.pop_front();
    vectors++;
    if ({if_id_valid_out, if_id_pc_out, if_id_ir_out, imem_read, imem_address} !==
        {1'b1, e.pc, e.ir, 1'b1, 16'h000A}) begin
      miscompares++;
      $display("FAIL stall_release: got %h want %h",
               {if_id_valid_out, if_id_pc_out, if_id_ir_out, imem_read, imem_address},
               {1'b1, e.pc, e.ir, 1'b1, 16'h000A});
    end
    push(16'h000C, memw(16'h000A));
    step(1'b1, memw(16'h000A), 1'b1, 1'b0, 16'h0);
    e = sb.pop_front();
    vectors++;
    if ({if_id_valid_out, if_id_pc_out, if_id_ir_out} !== {1'b1, e.pc, e.ir}) begin
      miscompares++;
      $display("FAIL stall_resume: got %h want %h",
               {if_id_valid_out, if_id_pc_out, if_id_ir_out}, {1'b1, e.pc, e.ir});
    end
  endtask

  task automatic test_redirect_mid;
    exp_t e;
    step(1'b0, 16'h0, 1'b1, 1'b1, 16'h3000);
    vectors++;
    if ({if_id_valid_out, if_id_ir_out, imem_read, imem_address} !==
        {1'b0, 16'h0000, 1'b1, 16'h000C}) begin
      miscompares++;
      $display("FAIL redir_flush: got %h want %h",
               {if_id_valid_out, if_id_ir_out, imem_read, imem_address},
               {1'b0, 16'h0000, 1'b1, 16'h000C});
    end
    step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
    step(1'b1, 16'hDEAD, 1'b1, 1'b0, 16'h0);
    vectors++;
    if ({if_id_valid_out, imem_read, imem_address} !== {1'b0, 1'b1, 16'h3000}) begin
      miscompares++;
      $display("FAIL redir_target: got %h want %h",
               {if_id_valid_out, imem_read, imem_address}, {1'b0, 1'b1, 16'h3000});
    end
    push(16'h3002, memw(16'h3000));
    step(1'b1, memw(16'h3000), 1'b1, 1'b0, 16'h0);
    e = sb.pop_front();
    vectors++;
    if ({if_id_valid_out, if_id_pc_out, if_id_ir_out} !== {1'b1, e.pc, e.ir}) begin
      miscompares++;
      $display("FAIL redir_first: got %h want %h",
               {if_id_valid_out, if_id_pc_out, if_id_ir_out}, {1'b1, e.pc, e.ir});
    end
    // Second redirect while squashing; odd target bit must be cleared.
    step(1'b0, 16'h0, 1'b1, 1'b1, 16'h4000);
    step(1'b0, 16'h0, 1'b1, 1'b1, 16'h5001);
    step(1'b1, 16'hBEEF, 1'b1, 1'b0, 16'h0);
    vectors++;
    if ({if_id_valid_out, imem_address} !== {1'b0, 16'h5000}) begin
      miscompares++;
      $display("FAIL redir_latest: got %h want %h", {if_id_valid_out, imem_address}, {1'b0, 16'h5000});
    end
    push(16'h5002, memw(16'h5000));
    step(1'b1, memw(16'h5000), 1'b1, 1'b0, 16'h0);
    e = sb.pop_front();
    vectors++;
    if ({if_id_valid_out, if_id_pc_out, if_id_ir_out} !== {1'b1, e.pc, e.ir}) begin
      miscompares++;
      $display("FAIL redir_latest_word: got %h want %h",
               {if_id_valid_out, if_id_pc_out, if_id_ir_out}, {1'b1, e.pc, e.ir});
    end
  endtask

  task automatic test_redirect_resp;
    exp_t e;
    step(1'b1, memw(16'h5002), 1'b1, 1'b1, 16'h6000);
    vectors++;
    if ({if_id_valid_out, if_id_ir_out, imem_read, imem_address} !==
        {1'b0, 16'h0000, 1'b1, 16'h6000}) begin
      miscompares++;
      $display("FAIL redir_resp: got %h want %h",
               {if_id_valid_out, if_id_ir_out, imem_read, imem_address},
               {1'b0, 16'h0000, 1'b1, 16'h6000});
    end
    step(1'b1, memw(16'h6000), 1'b0, 1'b0, 16'h0);
    step(1'b0, 16'h0, 1'b1, 1'b1, 16'h7000);
    vectors++;
    if ({if_id_valid_out, if_id_ir_out, imem_read, imem_address} !==
        {1'b0, 16'h0000, 1'b1, 16'h7000}) begin
      miscompares++;
      $display("FAIL redir_hold: got %h want %h",
               {if_id_valid_out, if_id_ir_out, imem_read, imem_address},
               {1'b0, 16'h0000, 1'b1, 16'h7000});
    end
    push(16'h7002, memw(16'h7000));
    step(1'b1, memw(16'h7000), 1'b1, 1'b0, 16'h0);
    e = sb.pop_front();
    vectors++;
    if ({if_id_valid_out, if_id_pc_out, if_id_ir_out} !== {1'b1, e.pc, e.ir}) begin
      miscompares++;
      $display("FAIL redir_hold_word: got %h want %h",
               {if_id_valid_out, if_id_pc_out, if_id_ir_out}, {1'b1, e.pc, e.ir});
    end
  endtask

  task automatic test_wrap;
    exp_t e;
    step(1'b0, 16'h0, 1'b1, 1'b1, 16'hFFFE);
    step(1'b1, 16'h0BAD, 1'b1, 1'b0, 16'h0);
    vectors++;
    if (imem_address !== 16'hFFFE) begin
      miscompares++;
      $display("FAIL wrap_addr: got %h want %h", imem_address, 16'hFFFE);
    end
    push(16'h0000, memw(16'hFFFE));
    step(1'b1, memw(16'hFFFE), 1'b1, 1'b0, 16'h0);
    e = sb.pop_front();
    vectors++;
    if ({if_id_valid_out, if_id_pc_out, if_id_ir_out, imem_address} !== {1'b1, e.pc, e.ir, 16'h0000}) begin
      miscompares++;
      $display("FAIL wrap_pc: got %h want %h",
               {if_id_valid_out, if_id_pc_out, if_id_ir_out, imem_address}, {1'b1, e.pc, e.ir, 16'h0000});
    end
  endtask

  // Random resp/load pattern without redirects; reference tracks pc and the hold buffer.
  task automatic test_back_to_back;
    exp_t e;
    logic [15:0] pc, held;
    logic holding, rs, ld, pushed;
    pc = 16'h0000; holding = 1'b0; held = 16'h0;
    for (int i = 0; i < 200; i++) begin
      vectors++;
      if ({imem_read, imem_address} !== {~holding, pc}) begin
        miscompares++;
        $display("FAIL b2b_req: got %h want %h", {imem_read, imem_address}, {~holding, pc});
      end
      ld = 1'($urandom_range(0, 3) != 0);
      rs = holding ? 1'b0 : 1'($urandom_range(0, 1));
      pushed = 1'b0;
      if (holding && ld) begin
        push(pc + 16'd2, held); pc = pc + 16'd2; holding = 1'b0; pushed = 1'b1;
      end else if (rs && ld) begin
        push(pc + 16'd2, memw(pc)); pc = pc + 16'd2; pushed = 1'b1;
      end else if (rs) begin
        held = memw(pc); holding = 1'b1;
      end
      step(rs, rs ? memw(imem_address) : 16'h0, ld, 1'b0, 16'h0);
      if (pushed) begin
        e = sb.pop_front();
        vectors++;
        if ({if_id_valid_out, if_id_pc_out, if_id_ir_out} !== {1'b1, e.pc, e.ir}) begin
          miscompares++;
          $display("FAIL b2b_ifid: got %h want %h",
                   {if_id_valid_out, if_id_pc_out, if_id_ir_out}, {1'b1, e.pc, e.ir});
        end
      end else if (ld) begin
        vectors++;
        if ({if_id_valid_out, if_id_ir_out} !== {1'b0, 16'h0000}) begin
          miscompares++;
          $display("FAIL b2b_bubble: got %h want %h", {if_id_valid_out, if_id_ir_out}, 17'h0);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_stream;
    test_stall;
    test_redirect_mid;
    test_redirect_resp;
    test_wrap;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
